// File: rtl/spu_mamulred_seq.sv
// Montgomery multiply/reduce sequencer: walks A/B word pointers, drains the multiplier, optional final subtract.
// Optional busy-cycle counter built only when SPU_MULRED_PERF_CNT_EN is defined.
module spu_mamulred_seq #(
  parameter int unsigned WORDS_W = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic               spu_maexp_start_mulred_aequb,
  input  logic               spu_maexp_start_mulred_anoteqb,
  input  logic               spu_mactl_kill_op,
  input  logic [WORDS_W-1:0] spu_madp_len,
  input  logic               spu_madp_ge_n,
  output logic               spu_mared_red_done,
  output logic               spu_mared_busy,
  output logic               spu_mared_memren,
  output logic [WORDS_W:0]   spu_mared_a_ptr,
  output logic [WORDS_W:0]   spu_mared_b_ptr,
  output logic               spu_mared_mul_vld,
  output logic               spu_mared_acc_wen,
  output logic               spu_mared_sub_en,
  output logic [15:0]        spu_mared_cyc_cnt
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_MUL   = 6'b000010,
    S_DRAIN = 6'b000100,
    S_CHK   = 6'b001000,
    S_SUB   = 6'b010000,
    S_DONE  = 6'b100000
  } state_e;

  localparam int unsigned DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [DW-1:0] DRN_LAST = DW'(MUL_LAT - 1);

  state_e               state_q, state_d;
  logic [WORDS_W-1:0]   len_q, len_d;
  logic                 aeqb_q, aeqb_d;
  logic [WORDS_W-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0]        drn_q, drn_d;
  logic                 mul_vld_q, mul_vld_d;
  logic [MUL_LAT-1:0]   acc_pipe_q, acc_pipe_d;
  logic                 start_ok, abort;

  assign start_ok = (state_q == S_IDLE) && !spu_mactl_kill_op &&
                    (spu_maexp_start_mulred_aequb || spu_maexp_start_mulred_anoteqb);
  assign abort    = spu_mactl_kill_op && (state_q != S_IDLE);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      aeqb_q     <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      mul_vld_q  <= 1'b0;
      acc_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      aeqb_q     <= aeqb_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      drn_q      <= drn_d;
      mul_vld_q  <= mul_vld_d;
      acc_pipe_q <= acc_pipe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    aeqb_d  = aeqb_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_MUL;
          len_d   = spu_madp_len;
          aeqb_d  = spu_maexp_start_mulred_aequb;
          i_d     = '0;
          j_d     = '0;
        end
      end
      // Compare against L before incrementing so L = 2**WORDS_W-1 never wraps.
      S_MUL: begin
        if (j_q == len_q) begin
          j_d = '0;
          if (i_q == len_q) begin
            state_d = S_DRAIN;
            i_d     = '0;
            drn_d   = '0;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = S_CHK;
        else                   drn_d   = drn_q + 1'b1;
      end
      S_CHK: begin
        state_d = spu_madp_ge_n ? S_SUB : S_DONE;
        k_d     = '0;
      end
      S_SUB: begin
        if (k_q == len_q) begin
          state_d = S_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      drn_d   = '0;
    end
  end

  // Only multiply-phase reads feed the multiplier; subtract-phase reads do not.
  always_comb begin
    mul_vld_d     = (state_q == S_MUL) && !abort;
    acc_pipe_d    = '0;
    acc_pipe_d[0] = mul_vld_q;
    for (int unsigned n = 1; n < MUL_LAT; n++) acc_pipe_d[n] = acc_pipe_q[n-1];
    if (abort) acc_pipe_d = '0;
  end

  always_comb begin
    spu_mared_memren   = (state_q == S_MUL) || (state_q == S_SUB);
    spu_mared_sub_en   = (state_q == S_SUB);
    spu_mared_red_done = (state_q == S_DONE);
    spu_mared_busy     = (state_q != S_IDLE);
    spu_mared_a_ptr    = '0;
    spu_mared_b_ptr    = '0;
    if (state_q == S_MUL) begin
      spu_mared_a_ptr = {1'b0, i_q};
      spu_mared_b_ptr = {~aeqb_q, j_q};
    end else if (state_q == S_SUB) begin
      spu_mared_a_ptr = {1'b0, k_q};
    end
    spu_mared_mul_vld = mul_vld_q;
    spu_mared_acc_wen = acc_pipe_q[MUL_LAT-1];
  end

`ifdef SPU_MULRED_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)                               cnt_d = '0;
    else if (state_q != S_IDLE && cnt_q != '1)  cnt_d = cnt_q + 16'd1;
  end

  assign spu_mared_cyc_cnt = cnt_q;
`else
  assign spu_mared_cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_spu_mamulred_seq.sv
// Directed bench for spu_mamulred_seq; cycle numbers count from the start cycle (cycle 0).
// Expected cyc_cnt follows SPU_MULRED_PERF_CNT_EN.
module tb_spu_mamulred_seq;
  localparam int unsigned WW  = 5;
  localparam int          LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st_aeqb = 1'b0, st_ane = 1'b0, kill = 1'b0, ge_n = 1'b0;
  logic [WW-1:0] len_i = '0;
  logic          red_done, busy, memren, mul_vld, acc_wen, sub_en;
  logic [WW:0]   a_ptr, b_ptr;
  logic [15:0]   cyc_cnt;

  spu_mamulred_seq #(.WORDS_W(WW), .MUL_LAT(LAT)) dut (
    .rclk                           (clk),
    .reset                          (rst),
    .spu_maexp_start_mulred_aequb   (st_aeqb),
    .spu_maexp_start_mulred_anoteqb (st_ane),
    .spu_mactl_kill_op              (kill),
    .spu_madp_len                   (len_i),
    .spu_madp_ge_n                  (ge_n),
    .spu_mared_red_done             (red_done),
    .spu_mared_busy                 (busy),
    .spu_mared_memren               (memren),
    .spu_mared_a_ptr                (a_ptr),
    .spu_mared_b_ptr                (b_ptr),
    .spu_mared_mul_vld              (mul_vld),
    .spu_mared_acc_wen              (acc_wen),
    .spu_mared_sub_en               (sub_en),
    .spu_mared_cyc_cnt              (cyc_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef SPU_MULRED_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  int   c_memren, c_mulvld, c_acc, last_acc, c_sub, c_done, done_cyc, ptr_err;
  logic b_msb_seen, busy1, busy_k;

  // Called at a negedge; drives a start at cycle 0 and samples cycles 1..budget mid-cycle.
  task automatic run_op(input logic sa, input logic sn, input logic [WW-1:0] len,
                        input logic gen, input int kill_at, input int restart_at, input int budget);
    int   n, sub0;
    logic exp_aeqb;
    n        = int'(len) + 1;
    sub0     = n * n + LAT + 2;
    exp_aeqb = sa;
    c_memren = 0; c_mulvld = 0; c_acc = 0; last_acc = -1; c_sub = 0;
    c_done = 0; done_cyc = -1; ptr_err = 0; b_msb_seen = 1'b0; busy1 = 1'b0; busy_k = 1'b1;
    st_aeqb = sa; st_ane = sn; len_i = len; ge_n = gen;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      st_aeqb = 1'b0; st_ane = 1'b0; kill = 1'b0;
      if (c == 1) busy1 = busy;
      if (c == kill_at + 1) busy_k = busy;
      if (memren) begin
        c_memren++;
        if (sub_en) begin
          if (a_ptr != (WW+1)'(c - sub0)) ptr_err++;
        end else begin
          if (b_ptr[WW]) b_msb_seen = 1'b1;
          if (c > n * n || a_ptr != (WW+1)'((c - 1) / n) ||
              b_ptr != {~exp_aeqb, WW'((c - 1) % n)}) ptr_err++;
        end
      end
      if (mul_vld) c_mulvld++;
      if (acc_wen) begin c_acc++; last_acc = c; end
      if (sub_en) c_sub++;
      if (red_done) begin c_done++; done_cyc = c; end
      if (c == kill_at)    kill   = 1'b1;
      if (c == restart_at) st_ane = 1'b1;
    end
  endtask

  initial begin
    #1;
    chk("reset_outs", {red_done, busy, memren, a_ptr, b_ptr, mul_vld, acc_wen, sub_en, cyc_cnt}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // square, L=0, no subtract
    run_op(1'b1, 1'b0, 5'd0, 1'b0, -1, -1, 20);
    chk("t1_memren", c_memren, 1);
    chk("t1_busy1", busy1, 1);
    chk("t1_acc_last", last_acc, 6);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_done_cnt", c_done, 1);
    chk("t1_ptr", ptr_err, 0);
    chk("t1_cyc_cnt", cyc_cnt, exp_cnt(7));

    // multiply, L=3, with subtract
    run_op(1'b0, 1'b1, 5'd3, 1'b1, -1, -1, 40);
    chk("t2_memren", c_memren, 20);
    chk("t2_acc", c_acc, 16);
    chk("t2_acc_last", last_acc, 21);
    chk("t2_sub", c_sub, 4);
    chk("t2_bmsb", b_msb_seen, 1);
    chk("t2_done_cyc", done_cyc, 26);
    chk("t2_ptr", ptr_err, 0);
    chk("t2_cyc_cnt", cyc_cnt, exp_cnt(26));
    chk("t2_busy_end", busy, 0);

    // both starts together: square wins
    run_op(1'b1, 1'b1, 5'd1, 1'b0, -1, -1, 30);
    chk("t3_bmsb", b_msb_seen, 0);
    chk("t3_ptr", ptr_err, 0);
    chk("t3_done_cyc", done_cyc, 10);

    // kill in MUL cycle 5
    run_op(1'b0, 1'b1, 5'd3, 1'b0, 5, -1, 40);
    chk("t4_memren", c_memren, 5);
    chk("t4_mulvld", c_mulvld, 4);
    chk("t4_acc", c_acc, 0);
    chk("t4_busy_k", busy_k, 0);
    chk("t4_done", c_done, 0);
    chk("t4_cyc_cnt", cyc_cnt, exp_cnt(5));

    // second start during DRAIN ignored, next start accepted
    run_op(1'b0, 1'b1, 5'd1, 1'b0, -1, 6, 40);
    chk("t5_done_cnt", c_done, 1);
    chk("t5_done_cyc", done_cyc, 10);
    run_op(1'b1, 1'b0, 5'd0, 1'b0, -1, -1, 20);
    chk("t5_next_done", done_cyc, 7);

    // perf count, L=3 no subtract
    run_op(1'b1, 1'b0, 5'd3, 1'b0, -1, -1, 40);
    chk("t6_done_cyc", done_cyc, 22);
    chk("t6_cyc_cnt", cyc_cnt, exp_cnt(22));

    // kill with start in IDLE: not launched
    kill = 1'b1; st_ane = 1'b1;
    @(negedge clk);
    kill = 1'b0; st_ane = 1'b0;
    chk("t7_kill_idle_busy", busy, 0);
    @(negedge clk);
    chk("t7_kill_idle_mem", memren, 0);

    // maximum length, subtract
    run_op(1'b0, 1'b1, 5'd31, 1'b1, -1, -1, 1080);
    chk("t8_memren", c_memren, 1056);
    chk("t8_sub", c_sub, 32);
    chk("t8_ptr", ptr_err, 0);
    chk("t8_done_cyc", done_cyc, 1062);

    // asynchronous reset mid-operation
    st_ane = 1'b1; len_i = 5'd3;
    @(negedge clk);
    st_ane = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t9_reset_outs", {red_done, busy, memren, a_ptr, b_ptr, mul_vld, acc_wen, sub_en, cyc_cnt}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(1'b1, 1'b0, 5'd0, 1'b0, -1, -1, 20);
    chk("t9_after_done", done_cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
